// File: rtl/instruction_fetcher.sv
// Fetch engine: latches the PC on request, reads program memory over valid/ready and holds the word until acked.
// Optional one-entry last-fetch buffer enabled by defining FETCHER_LAST_HIT_EN.
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             fetch_req,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
  input  logic                             fetch_ack,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             instr_valid,
  output logic [1:0]                       fetcher_state
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FETCHING = 2'd1;
  localparam logic [1:0] FETCHED  = 2'd2;

  logic [1:0]                       state_r;
  logic [1:0]                       state_s;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_r;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_r;
  logic                             hit_s;
  logic [PROGRAM_MEM_DATA_BITS-1:0] hit_data_s;

`ifdef FETCHER_LAST_HIT_EN
  logic                             buf_valid_r;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_addr_r;
  logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data_r;

  // Last-fetch buffer: refreshed on every memory capture; flush wins over a same-edge capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_r <= 1'b0;
      buf_addr_r  <= '0;
      buf_data_r  <= '0;
    end else if (flush) begin
      buf_valid_r <= 1'b0;
    end else if (state_r == FETCHING && mem_read_ready) begin
      buf_valid_r <= 1'b1;
      buf_addr_r  <= addr_r;
      buf_data_r  <= mem_read_data;
    end
  end

  // A flush in the request cycle forces a miss.
  always_comb begin
    hit_s      = buf_valid_r && !flush && (buf_addr_r == pc);
    hit_data_s = buf_data_r;
  end
`else
  logic unused_flush_s;
  assign unused_flush_s = flush;

  // Without the buffer every fetch is a miss.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = '0;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Next-state logic; the unused encoding recovers to IDLE.
  always_comb begin
    state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (fetch_req) state_s = hit_s ? FETCHED : FETCHING;
        else           state_s = IDLE;
      end
      FETCHING: begin
        if (mem_read_ready) state_s = FETCHED;
        else                state_s = FETCHING;
      end
      FETCHED: begin
        if (fetch_ack) state_s = IDLE;
        else           state_s = FETCHED;
      end
      default: state_s = IDLE;
    endcase
  end

  // Address latch and instruction capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r  <= '0;
      instr_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fetch_req) begin
            addr_r <= pc;
            if (hit_s) instr_r <= hit_data_s;
          end
        end
        FETCHING: begin
          if (mem_read_ready) instr_r <= mem_read_data;
        end
        default: ;
      endcase
    end
  end

  // Output decodes of the state register only.
  always_comb begin
    mem_read_valid = 1'b0;
    instr_valid    = 1'b0;
    case (state_r)
      FETCHING: mem_read_valid = 1'b1;
      FETCHED:  instr_valid    = 1'b1;
      default:  ;
    endcase
  end

  assign mem_read_address = addr_r;
  assign instruction      = instr_r;
  assign fetcher_state    = state_r;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed vector table, corner sequences and random fetches
// against a transaction-level model (memory array plus last-fetch buffer when FETCHER_LAST_HIT_EN is defined).
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [7:0]  pc = 8'd0;
  logic        fetch_ack = 1'b0;
  logic        flush = 1'b0;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'd0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [1:0]  fetcher_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_model [256];
  logic        buf_v = 1'b0;
  logic [7:0]  buf_a = 8'd0;
  logic [15:0] buf_d = 16'd0;
  logic [15:0] last_instr = 16'd0;

  typedef struct {
    logic [7:0]  addr;
    int          ready_at;
    logic [15:0] data;
    int          exp_lat;
  } vec_t;
  vec_t vecs [5];

  instruction_fetcher dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .pc(pc),
    .fetch_ack(fetch_ack), .flush(flush), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .instruction(instruction),
    .instr_valid(instr_valid), .fetcher_state(fetcher_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit(input logic [7:0] a, input bit fl);
`ifdef FETCHER_LAST_HIT_EN
    return buf_v && !fl && (buf_a == a);
`else
    return 1'b0;
`endif
  endfunction

  // One fetch from IDLE: memory answers in its k-th FETCHING cycle with d.
  task automatic do_fetch(input string nm, input logic [7:0] a, input int k, input logic [15:0] d,
                          input bit fl, input int exp_lat, input int exp_v, input logic [15:0] exp_i);
    int lat = 0;
    int vcyc = 0;
    bit addr_ok = 1'b1;
    fetch_req = 1'b1; pc = a; flush = fl; fetch_ack = 1'b0;
    tick();
    fetch_req = 1'($urandom); pc = 8'($urandom); flush = 1'b0;
    lat = 1;
    while (!instr_valid && lat <= 20) begin
      if (mem_read_valid) vcyc++;
      if (mem_read_address !== a) addr_ok = 1'b0;
      mem_read_ready = (vcyc == k);
      mem_read_data  = (vcyc == k) ? d : 16'($urandom);
      fetch_ack = 1'($urandom);
      tick();
      lat++;
    end
    fetch_ack = 1'b0; mem_read_ready = 1'b0; fetch_req = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_valid_cycles"}, 32'(vcyc), 32'(exp_v));
    chk({nm, "_addr_stable"}, {31'd0, addr_ok}, 32'd1);
    chk({nm, "_instr"}, {16'd0, instruction}, {16'd0, exp_i});
    chk({nm, "_state"}, {30'd0, fetcher_state}, 32'd2);
    chk({nm, "_no_valid_in_fetched"}, {31'd0, mem_read_valid}, 32'd0);
    last_instr = exp_i;
  endtask

  // Model update after a completed fetch.
  task automatic model_fetch(input logic [7:0] a, input logic [15:0] d, input bit fl, input bit hit);
`ifdef FETCHER_LAST_HIT_EN
    if (fl) buf_v = 1'b0;
    if (!hit) begin buf_v = 1'b1; buf_a = a; buf_d = d; end
`else
    buf_v = 1'b0;
    if (fl || hit || a == d[7:0]) buf_a = buf_a;
`endif
  endtask

  // Stay in FETCHED for n cycles with noise on ignored inputs, then ack.
  task automatic hold_ack(input string nm, input int n);
    bit stable = 1'b1;
    for (int i = 0; i < n; i++) begin
      fetch_req = 1'($urandom); mem_read_ready = 1'($urandom); mem_read_data = 16'($urandom);
      tick();
      if (instruction !== last_instr || !instr_valid || fetcher_state !== 2'd2 || mem_read_valid) stable = 1'b0;
    end
    fetch_req = 1'b0; mem_read_ready = 1'b0; fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    chk({nm, "_hold_stable"}, {31'd0, stable}, 32'd1);
    chk({nm, "_ack_state"}, {30'd0, fetcher_state}, 32'd0);
    chk({nm, "_ack_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({nm, "_ack_retains"}, {16'd0, instruction}, {16'd0, last_instr});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
    mem_model[8'h20] = 16'h1234;
    vecs[0] = '{8'h12, 1, 16'hA5C3, 2};
    vecs[1] = '{8'h34, 4, 16'h0F0F, 5};
    vecs[2] = '{8'hFF, 2, 16'hFFFF, 3};
    vecs[3] = '{8'h00, 1, 16'h0000, 2};
    vecs[4] = '{8'h80, 3, 16'h8001, 4};

    #12;
    chk("rst_state", {30'd0, fetcher_state}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_read_valid}, 32'd0);
    chk("rst_addr", {24'd0, mem_read_address}, 32'd0);
    chk("rst_instr", {16'd0, instruction}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Ignored inputs in IDLE: ack and a stray memory response.
    fetch_ack = 1'b1; mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
    tick(); tick();
    fetch_ack = 1'b0; mem_read_ready = 1'b0;
    chk("idle_ignore_state", {30'd0, fetcher_state}, 32'd0);
    chk("idle_ignore_instr", {16'd0, instruction}, 32'd0);

    foreach (vecs[i]) begin
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ready_at, vecs[i].data, 1'b0,
               vecs[i].exp_lat, vecs[i].ready_at, vecs[i].data);
      model_fetch(vecs[i].addr, vecs[i].data, 1'b0, 1'b0);
      hold_ack($sformatf("vec%0d", i), (i == 1) ? 10 : 0);
    end

    // Re-fetch of the same address: buffer hit if enabled, otherwise a full miss; then flush forces a miss.
    do_fetch("fetch20", 8'h20, 1, 16'h1234, 1'b0, 2, 1, 16'h1234);
    model_fetch(8'h20, 16'h1234, 1'b0, 1'b0);
    hold_ack("fetch20", 1);
    begin
      bit h;
      h = model_hit(8'h20, 1'b0);
      do_fetch("refetch20", 8'h20, 2, 16'h1234, 1'b0, h ? 1 : 3, h ? 0 : 2, 16'h1234);
      model_fetch(8'h20, 16'h1234, 1'b0, h);
      hold_ack("refetch20", 0);
      h = model_hit(8'h20, 1'b1);
      chk("flush_forces_miss", {31'd0, h}, 32'd0);
      do_fetch("flush20", 8'h20, 1, 16'h1234, 1'b1, 2, 1, 16'h1234);
      model_fetch(8'h20, 16'h1234, 1'b1, h);
      hold_ack("flush20", 0);
    end

    // Randomized fetches against the model.
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  a;
      logic [15:0] e;
      int          k;
      bit          fl;
      bit          h;
      a  = 8'($urandom_range(16, 23));
      k  = $urandom_range(1, 5);
      fl = ($urandom_range(0, 3) == 0);
      h  = model_hit(a, fl);
      e  = h ? buf_d : mem_model[a];
      do_fetch($sformatf("rnd%0d", t), a, k, mem_model[a], fl, h ? 1 : k + 1, h ? 0 : k, e);
      model_fetch(a, mem_model[a], fl, h);
      hold_ack($sformatf("rnd%0d", t), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of FETCHING.
    fetch_req = 1'b1; pc = 8'h55;
    tick();
    fetch_req = 1'b0;
    chk("pre_rst_fetching", {31'd0, mem_read_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_valid", {31'd0, mem_read_valid}, 32'd0);
    chk("mid_rst_state", {30'd0, fetcher_state}, 32'd0);
    chk("mid_rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr", {16'd0, instruction}, 32'd0);
    tick();
    reset_n = 1'b1;
    buf_v = 1'b0;
    tick();
    chk("post_rst_idle", {30'd0, fetcher_state}, 32'd0);
    do_fetch("post_rst20", 8'h20, 1, 16'h1234, 1'b0, 2, 1, 16'h1234);
    hold_ack("post_rst20", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
